// File: rtl/prime_candidate_gen.sv
// Assembles an RSA prime candidate from consecutive LFSR words, forcing MSB/LSB high,
// and offers it on a valid/ready handshake; flags a locked (all-zero) LFSR stickily.
module prime_candidate_gen #(
    parameter int WORD_WIDTH  = 32,
    parameter int CHUNK_WIDTH = WORD_WIDTH / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CHUNK_WIDTH-1:0] rand_in,
    output logic                   busy,
    output logic                   cand_valid,
    input  logic                   cand_ready,
    output logic [WORD_WIDTH-1:0]  candidate,
    output logic                   err_stuck
);

    localparam int NUM_CHUNKS = WORD_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [WORD_WIDTH-1:0] FORCE_MASK = {1'b1, {(WORD_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic [WORD_WIDTH-1:0]   cand_q, cand_d;
    logic                    err_q, err_d;
    logic                    busy_q, valid_q;
    logic [WORD_WIDTH-1:0]   shreg_next_s;
    logic                    chunk_zero_s;

    // First sampled chunk migrates to the most significant position.
    assign shreg_next_s = {shreg_q[WORD_WIDTH-CHUNK_WIDTH-1:0], rand_in};
    assign chunk_zero_s = (rand_in == {CHUNK_WIDTH{1'b0}});

    // Next-state logic for the collection FSM and its datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        cand_d  = cand_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    cnt_d   = {CNT_W{1'b0}};
                    shreg_d = {WORD_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (chunk_zero_s) begin
                    // A zero word means the LFSR has locked: abandon this candidate.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = shreg_next_s;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        cand_d  = shreg_next_s | FORCE_MASK;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_DONE: begin
                if (cand_ready) begin
                    if (start) begin
                        state_d = ST_COLLECT;
                        cnt_d   = {CNT_W{1'b0}};
                        shreg_d = {WORD_WIDTH{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status outputs are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            shreg_q <= {WORD_WIDTH{1'b0}};
            cand_q  <= {WORD_WIDTH{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            cand_q  <= cand_d;
            err_q   <= err_d;
            busy_q  <= (state_d != ST_IDLE);
            valid_q <= (state_d == ST_DONE);
        end
    end

    assign busy       = busy_q;
    assign cand_valid = valid_q;
    assign candidate  = cand_q;
    assign err_stuck  = err_q;

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Randomized bench for prime_candidate_gen (32/16 and 64/16 instances sharing stimulus),
// checked every cycle against an arithmetic model, plus literal expectations.
module tb_prime_candidate_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] rand_in;
    logic        cand_ready;

    logic        b32, v32, e32;
    logic [31:0] c32;
    logic        b64, v64, e64;
    logic [63:0] c64;

    int n_vec = 0;
    int n_err = 0;

    prime_candidate_gen #(.WORD_WIDTH(32), .CHUNK_WIDTH(16)) u32 (
        .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
        .busy(b32), .cand_valid(v32), .cand_ready(cand_ready),
        .candidate(c32), .err_stuck(e32)
    );

    prime_candidate_gen #(.WORD_WIDTH(64), .CHUNK_WIDTH(16)) u64 (
        .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
        .busy(b64), .cand_valid(v64), .cand_ready(cand_ready),
        .candidate(c64), .err_stuck(e64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 collecting, 2 offering a candidate.
    int          m_mode [2] = '{0, 0};
    int          m_n    [2] = '{0, 0};
    logic [63:0] m_acc  [2] = '{64'd0, 64'd0};
    logic [63:0] m_cand [2] = '{64'd0, 64'd0};
    logic        m_err  [2] = '{1'b0, 1'b0};

    task automatic model_step(input int i, input int w, input int nch);
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (m_mode[i] == 0) begin
            if (start) begin m_mode[i] = 1; m_n[i] = 0; m_acc[i] = 64'd0; end
        end else if (m_mode[i] == 1) begin
            if (rand_in == 16'd0) begin
                m_err[i] = 1'b1;
                m_mode[i] = 0;
            end else begin
                m_acc[i] = ((m_acc[i] * 64'd65536) + {48'd0, rand_in}) & mask;
                m_n[i]   = m_n[i] + 1;
                if (m_n[i] == nch) begin
                    m_cand[i] = m_acc[i] | (64'd1 << (w - 1)) | 64'd1;
                    m_mode[i] = 2;
                end
            end
        end else begin
            if (cand_ready) begin
                if (start) begin m_mode[i] = 1; m_n[i] = 0; m_acc[i] = 64'd0; end
                else m_mode[i] = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_n[i] = 0; m_acc[i] = 64'd0; m_cand[i] = 64'd0; m_err[i] = 1'b0;
            end
        end else begin
            model_step(0, 32, 2);
            model_step(1, 64, 4);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("busy32",  {63'd0, b32}, {63'd0, m_mode[0] != 0});
        chk("valid32", {63'd0, v32}, {63'd0, m_mode[0] == 2});
        chk("cand32",  {32'd0, c32}, m_cand[0]);
        chk("err32",   {63'd0, e32}, {63'd0, m_err[0]});
        chk("busy64",  {63'd0, b64}, {63'd0, m_mode[1] != 0});
        chk("valid64", {63'd0, v64}, {63'd0, m_mode[1] == 2});
        chk("cand64",  c64, m_cand[1]);
        chk("err64",   {63'd0, e64}, {63'd0, m_err[1]});
    end

    function automatic logic [15:0] rnz();
        return 16'($urandom_range(1, 65535));
    endfunction

    task automatic drive(input logic s, input logic [15:0] r, input logic rd);
        start      = s;
        rand_in    = r;
        cand_ready = rd;
        @(negedge clk);
    endtask

    task automatic settle();
        for (int k = 0; k < 6; k++) drive(1'b0, rnz(), 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rand_in = 16'h0001; cand_ready = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {63'd0, b32}, 64'd0);
        chk("rst_valid", {63'd0, v32}, 64'd0);
        chk("rst_cand",  {32'd0, c32}, 64'd0);
        chk("rst_err",   {63'd0, e32}, 64'd0);
        rst = 1'b0;
        drive(1'b0, rnz(), 1'b0);

        // Basic assembly and backpressure
        drive(1'b1, 16'h0000, 1'b0);
        drive(1'b0, 16'h1234, 1'b0);
        chk("t1_notyet", {63'd0, v32}, 64'd0);
        drive(1'b0, 16'h5678, 1'b0);
        chk("t1_valid", {63'd0, v32}, 64'd1);
        chk("t1_cand",  {32'd0, c32}, 64'h92345679);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, rnz(), 1'b0);
            chk("t2_hold_valid", {63'd0, v32}, 64'd1);
            chk("t2_hold_cand",  {32'd0, c32}, 64'h92345679);
        end
        drive(1'b0, rnz(), 1'b1);
        chk("t2_released", {63'd0, v32}, 64'd0);
        chk("t1_idle",     {63'd0, b32}, 64'd0);

        // Lock detection
        drive(1'b1, rnz(), 1'b1);
        drive(1'b0, 16'hABCD, 1'b1);
        drive(1'b0, 16'h0000, 1'b1);
        chk("t3_err",   {63'd0, e32}, 64'd1);
        chk("t3_idle",  {63'd0, b32}, 64'd0);
        chk("t3_novld", {63'd0, v32}, 64'd0);
        chk("t3_keep",  {32'd0, c32}, 64'h92345679);
        drive(1'b1, rnz(), 1'b0);
        drive(1'b0, 16'h0001, 1'b0);
        drive(1'b0, 16'h8000, 1'b0);
        chk("t3_cand",   {32'd0, c32}, 64'h80018001);
        chk("t3_sticky", {63'd0, e32}, 64'd1);
        settle();

        // Back-to-back with start held, and start ignored during collection
        drive(1'b1, rnz(), 1'b1);
        drive(1'b1, 16'h4321, 1'b1);
        drive(1'b1, 16'h8765, 1'b1);
        chk("t4_cand_a", {32'd0, c32}, 64'hC3218765);
        drive(1'b1, rnz(), 1'b1);
        chk("t4_reenter", {63'd0, b32}, 64'd1);
        chk("t4_reenter_v", {63'd0, v32}, 64'd0);
        drive(1'b1, 16'h1357, 1'b0);
        drive(1'b0, 16'h2468, 1'b0);
        chk("t4_two_samples", {63'd0, v32}, 64'd1);
        chk("t4_cand_b", {32'd0, c32}, 64'h93572469);
        settle();

        // Asynchronous reset mid-collection
        drive(1'b1, rnz(), 1'b0);
        drive(1'b0, rnz(), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy",  {63'd0, b32}, 64'd0);
        chk("t5_valid", {63'd0, v32}, 64'd0);
        chk("t5_cand",  {32'd0, c32}, 64'd0);
        chk("t5_err",   {63'd0, e32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, rnz(), 1'b0);
        drive(1'b0, 16'hFFFF, 1'b0);
        drive(1'b0, 16'hFFFE, 1'b0);
        chk("t5_cand_new", {32'd0, c32}, 64'hFFFFFFFF);
        settle();

        // Wide configuration
        drive(1'b1, rnz(), 1'b0);
        drive(1'b0, 16'h0102, 1'b0);
        drive(1'b0, 16'h0304, 1'b0);
        drive(1'b0, 16'h0506, 1'b0);
        chk("t6_notyet", {63'd0, v64}, 64'd0);
        drive(1'b0, 16'h0708, 1'b0);
        chk("t6_valid", {63'd0, v64}, 64'd1);
        chk("t6_cand",  c64, 64'h8102030405060709);
        settle();

        // Randomized traffic with occasional locks and asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            start      = ($urandom_range(0, 2) == 0);
            cand_ready = ($urandom_range(0, 1) == 1);
            rand_in    = ($urandom_range(0, 39) == 0) ? 16'h0000 : rnz();
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
